irig_encoder: RTL and testbench
===============================

Name: irig_encoder

Overview:
- Generates a 100 pps IRIG-B (B00x, pulse-width coded) time-code frame each second from BCD time fields plus straight-binary seconds-of-day.
- Produces the level-coded `irig_out` and per-bit symbol strobes (`sym_d0`, `sym_d1`, `sym_mark`) with the same meaning as the decoder's d0/d1/mark inputs, so the encoder can drive the decoder directly in loopback.
- Sits on the timing board as the IRIG master source.
- Each frame is started by a PPS pulse.

Parameters:
- `CLKS_PER_MS`, 100000, clk cycles per 1 ms. Minimum 2. Counter width is `$clog2(CLKS_PER_MS)`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous reset, active-low.
- `enable`  in  1  allows a PPS to start a new frame.
- `pps`  in  1  one-cycle pulse, synchronous to `clk`; marks the on-time edge.
- `sec_bcd`  in  7  [6:4] tens, [3:0] units.
- `min_bcd`  in  7  [6:4] tens, [3:0] units.
- `hour_bcd`  in  6  [5:4] tens, [3:0] units.
- `day_bcd`  in  10  [9:8] hundreds, [7:4] tens, [3:0] units.
- `year_bcd`  in  8  [7:4] tens, [3:0] units.
- `sbs`  in  17  seconds of day, binary, 0..86399.
- `irig_out`  out  1  pulse-width-coded IRIG-B level.
- `sym_d0`  out  1  one-cycle strobe at the start of a "0" bit.
- `sym_d1`  out  1  one-cycle strobe at the start of a "1" bit.
- `sym_mark`  out  1  one-cycle strobe at the start of Pr or P1..P0.
- `busy`  out  1  a frame is in progress.
- `bit_idx`  out  7  current bit, 0..99.
- `resync`  out  1  one-cycle pulse when a PPS restarts an unfinished frame.

Behaviour:
- Reset (async assert, sync release): all outputs 0, timing counters 0, FSM in IDLE.
- Reset mid-frame: `irig_out` goes low immediately; no partial frame resumes.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on `pps & enable`.
  - RUN -> IDLE after the last cycle of bit 99, unless `pps & enable` arrives in that same cycle; in that case RUN continues seamlessly with bit 0.
- Frame start:
  - The cycle `pps & enable` is sampled, all time inputs are latched into a frame shadow register.
  - Inputs are ignored for the rest of the frame.
- Latency: PPS sampled in cycle T gives `irig_out`=1, `sym_mark`=1, `bit_idx`=0 in cycle T+1 (registered outputs).
- Timing:
  - A cycle counter counts 0..`CLKS_PER_MS`-1 and carries into a ms counter 0..9.
  - The ms counter carries into `bit_idx` 0..99.
  - One bit = 10 ms = 10*`CLKS_PER_MS` cycles.
- Pulse width:
  - `irig_out`=1 while ms < W, then 0 for the rest of the bit.
  - W = 8 for a mark, 5 for a "1", 2 for a "0".
- Strobes:
  - Exactly one of `sym_d0`/`sym_d1`/`sym_mark` pulses for one cycle at cycle 0 of each bit in RUN.
  - No strobes in IDLE.
- Bit map (BCD digits LSB first, unused bits = "0"):
  - Marks: bit 0 (Pr) and bits 9, 19, 29, ..., 99.
  - Seconds: units at 1-4, 5=0, tens at 6-8.
  - Minutes: units at 10-13, 14=0, tens at 15-17, 18=0.
  - Hours: units at 20-23, 24=0, tens at 25-26, 27-28=0.
  - Day: units at 30-33, 34=0, tens at 35-38, hundreds at 40-41, 42-48=0.
  - Year: units at 50-53, 54=0, tens at 55-58.
  - Control functions: 60-78 all 0.
  - SBS: [8:0] at 80-88, [16:9] at 90-97, 98=0.
- Early PPS: `pps & enable` while RUN and `bit_idx`≠99-last-cycle:
  - Abort the current frame and relatch inputs.
  - Restart at bit 0 in the next cycle.
  - Pulse `resync` for one cycle.
- `enable` deasserted mid-frame: the current frame completes; any following PPS is ignored.
- `pps` while `enable`=0: no effect, including in RUN.
- `busy` = (state == RUN), registered.
- No input range checking; non-BCD nibbles are transmitted as given.

Test Plan (`CLKS_PER_MS`=4: 40 cycles/bit, 4000 cycles/frame):
1. Reset, then PPS with 12:34:56, day 123, year 24, sbs 45296.
   - T+1: `sym_mark`=1, `irig_out` high for 32 cycles.
   - Bits 1-4 = 0,1,1,0 (units 6); bits 6-8 = 1,0,1 (tens 5).
   - Bit 80 = 0; SBS field decodes to 45296.
   - Bit 99 = mark; then IDLE, `busy`=0.
2. Pulse widths: a "1" bit is high 20 cycles, a "0" bit is high 8 cycles, a mark is high 32 cycles, each followed by low to the 40-cycle boundary.
3. PPS on the last cycle of bit 99: next cycle is bit 0 (`sym_mark`), no `resync`, `busy` stays 1, new time latched.
4. PPS at bit 37, cycle 5: `resync` pulses once, `bit_idx`=0 next cycle, `irig_out` restarts high for 32 cycles.
5. Assert `rst_n`=0 at bit 50:
   - Outputs go to 0 immediately.
   - After release, no strobes until the next PPS.
6. `enable`=0 at bit 20: the frame completes through bit 99; a later PPS produces no activity. Loopback into the IRIG decoder reaches `ts_select` SEC_DAY with the correct bits.

Source files
------------

// File: rtl/irig_encoder.sv
// irig_encoder: PPS-started IRIG-B (B00x) pulse-width-coded frame generator with per-bit symbol strobes
module irig_encoder #(
  parameter int CLKS_PER_MS = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        pps,
  input  logic [6:0]  sec_bcd,
  input  logic [6:0]  min_bcd,
  input  logic [5:0]  hour_bcd,
  input  logic [9:0]  day_bcd,
  input  logic [7:0]  year_bcd,
  input  logic [16:0] sbs,
  output logic        irig_out,
  output logic        sym_d0,
  output logic        sym_d1,
  output logic        sym_mark,
  output logic        busy,
  output logic [6:0]  bit_idx,
  output logic        resync
);
  localparam int CW = $clog2(CLKS_PER_MS);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_nxt_state;
  logic [CW-1:0] r_cyc, w_cyc;
  logic [3:0] r_ms, w_ms, w_width;
  logic [6:0] r_bit, w_bit;
  logic [6:0] r_sec, r_min;
  logic [5:0] r_hour;
  logic [9:0] r_day;
  logic [7:0] r_year;
  logic [16:0] r_sbs;
  logic [99:0] w_data;
  logic w_start, w_cyc_wrap, w_ms_wrap, w_last, w_mark, w_one, w_run, w_sym;
  assign w_start = pps & enable;
  assign w_cyc_wrap = r_cyc == CW'(CLKS_PER_MS - 1);
  assign w_ms_wrap = w_cyc_wrap && r_ms == 4'd9;
  assign w_last = r_state == RUN && w_ms_wrap && r_bit == 7'd99;
  assign bit_idx = r_bit;
  // A start (fresh or early) forces the counters to bit 0 in the next cycle
  always_comb begin
    w_nxt_state = r_state;
    w_cyc = '0;
    w_ms = '0;
    w_bit = '0;
    if (w_start) w_nxt_state = RUN;
    else if (r_state == RUN && !w_last) begin
      w_cyc = w_cyc_wrap ? '0 : r_cyc + 1'b1;
      w_ms = w_ms_wrap ? 4'd0 : w_cyc_wrap ? r_ms + 4'd1 : r_ms;
      w_bit = w_ms_wrap ? r_bit + 7'd1 : r_bit;
    end else w_nxt_state = IDLE;
  end
  always_comb begin
    w_data = '0;
    w_data[4:1] = r_sec[3:0];
    w_data[8:6] = r_sec[6:4];
    w_data[13:10] = r_min[3:0];
    w_data[17:15] = r_min[6:4];
    w_data[23:20] = r_hour[3:0];
    w_data[26:25] = r_hour[5:4];
    w_data[33:30] = r_day[3:0];
    w_data[38:35] = r_day[7:4];
    w_data[41:40] = r_day[9:8];
    w_data[53:50] = r_year[3:0];
    w_data[58:55] = r_year[7:4];
    w_data[88:80] = r_sbs[8:0];
    w_data[97:90] = r_sbs[16:9];
  end
  // Outputs are registered from next-cycle counter values so they align with bit_idx
  assign w_mark = w_bit == 7'd0 || (w_bit % 7'd10) == 7'd9;
  assign w_one = w_data[w_bit];
  assign w_width = w_mark ? 4'd8 : w_one ? 4'd5 : 4'd2;
  assign w_run = w_nxt_state == RUN;
  assign w_sym = w_run && w_cyc == '0 && w_ms == 4'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cyc <= '0;
      r_ms <= '0;
      r_bit <= '0;
      r_sec <= '0;
      r_min <= '0;
      r_hour <= '0;
      r_day <= '0;
      r_year <= '0;
      r_sbs <= '0;
      irig_out <= 1'b0;
      sym_d0 <= 1'b0;
      sym_d1 <= 1'b0;
      sym_mark <= 1'b0;
      busy <= 1'b0;
      resync <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cyc <= w_cyc;
      r_ms <= w_ms;
      r_bit <= w_bit;
      if (w_start) begin
        r_sec <= sec_bcd;
        r_min <= min_bcd;
        r_hour <= hour_bcd;
        r_day <= day_bcd;
        r_year <= year_bcd;
        r_sbs <= sbs;
      end
      irig_out <= w_run && w_ms < w_width;
      sym_mark <= w_sym && w_mark;
      sym_d1 <= w_sym && !w_mark && w_one;
      sym_d0 <= w_sym && !w_mark && !w_one;
      busy <= w_run;
      resync <= w_start && r_state == RUN && !w_last;
    end
  end
endmodule

// File: tb/tb_irig_encoder.sv
// tb_irig_encoder: directed self-checking bench for irig_encoder with 4 clocks per ms
module tb_irig_encoder;
  typedef struct packed {
    logic [6:0]  sec;
    logic [6:0]  min;
    logic [5:0]  hour;
    logic [9:0]  day;
    logic [7:0]  year;
    logic [16:0] sbs;
  } tv_t;
  localparam tv_t TA = '{sec: 7'h56, min: 7'h34, hour: 6'h12, day: 10'h123, year: 8'h24, sbs: 17'd45296};
  localparam tv_t TB = '{sec: 7'h07, min: 7'h59, hour: 6'h23, day: 10'h365, year: 8'h99, sbs: 17'd86399};
  localparam tv_t TC = '{sec: 7'h1F, min: 7'h00, hour: 6'h00, day: 10'h001, year: 8'h00, sbs: 17'd1};
  logic clk = 1'b0;
  logic rst_n, enable, pps;
  logic [6:0] sec_bcd, min_bcd;
  logic [5:0] hour_bcd;
  logic [9:0] day_bcd;
  logic [7:0] year_bcd;
  logic [16:0] sbs;
  logic irig_out, sym_d0, sym_d1, sym_mark, busy, resync;
  logic [6:0] bit_idx;
  int checks = 0, errors = 0;
  int hi [100];
  int sy [100];
  int bi [100];
  int rs_cnt, extra;
  irig_encoder #(.CLKS_PER_MS(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pps(pps),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .day_bcd(day_bcd),
    .year_bcd(year_bcd), .sbs(sbs), .irig_out(irig_out), .sym_d0(sym_d0), .sym_d1(sym_d1),
    .sym_mark(sym_mark), .busy(busy), .bit_idx(bit_idx), .resync(resync)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_time(input tv_t t);
    sec_bcd = t.sec;
    min_bcd = t.min;
    hour_bcd = t.hour;
    day_bcd = t.day;
    year_bcd = t.year;
    sbs = t.sbs;
  endtask
  task automatic start_pps;
    pps = 1'b1;
    tick;
    pps = 1'b0;
  endtask
  function automatic int exp_code(input int b, input tv_t t);
    if (b == 0 || b % 10 == 9) return 2;
    if (b >= 1 && b <= 4) return int'(t.sec[b-1]);
    if (b >= 6 && b <= 8) return int'(t.sec[b-2]);
    if (b >= 10 && b <= 13) return int'(t.min[b-10]);
    if (b >= 15 && b <= 17) return int'(t.min[b-11]);
    if (b >= 20 && b <= 23) return int'(t.hour[b-20]);
    if (b >= 25 && b <= 26) return int'(t.hour[b-21]);
    if (b >= 30 && b <= 33) return int'(t.day[b-30]);
    if (b >= 35 && b <= 38) return int'(t.day[b-31]);
    if (b >= 40 && b <= 41) return int'(t.day[b-32]);
    if (b >= 50 && b <= 53) return int'(t.year[b-50]);
    if (b >= 55 && b <= 58) return int'(t.year[b-51]);
    if (b >= 80 && b <= 88) return int'(t.sbs[b-80]);
    if (b >= 90 && b <= 97) return int'(t.sbs[b-81]);
    return 0;
  endfunction
  // Records one full frame starting at the current sample point (bit 0, cycle 0)
  task automatic capture(input int pps_k, input int dis_k);
    int k;
    k = 0;
    rs_cnt = 0;
    extra = 0;
    for (int b = 0; b < 100; b++) begin
      hi[b] = 0;
      for (int c = 0; c < 40; c++) begin
        if (c == 0) begin
          sy[b] = sym_mark ? 2 : sym_d1 ? 1 : sym_d0 ? 0 : 3;
          bi[b] = int'(bit_idx);
          if ($countones({sym_d0, sym_d1, sym_mark}) != 1) extra++;
        end else if (sym_d0 | sym_d1 | sym_mark) extra++;
        if (irig_out) hi[b]++;
        if (resync) rs_cnt++;
        if (k == pps_k) pps = 1'b1;
        if (k == dis_k) enable = 1'b0;
        tick;
        pps = 1'b0;
        k++;
      end
    end
  endtask
  task automatic test_reset;
    checks++;
    if ({irig_out, sym_d0, sym_d1, sym_mark, busy, resync, bit_idx} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {irig_out, sym_d0, sym_d1, sym_mark, busy, resync, bit_idx});
    end
    rst_n = 1'b1;
    pps = 1'b1;
    tick;
    pps = 1'b0;
    tick;
    checks++;
    if ({busy, sym_mark, irig_out} !== 3'b000) begin
      errors++;
      $display("FAIL idle_pps_disabled: busy/mark/irig %b want 000", {busy, sym_mark, irig_out});
    end
    enable = 1'b1;
  endtask
  task automatic test_frame;
    int v;
    set_time(TA);
    start_pps;
    set_time(TB);
    checks++;
    if ({sym_mark, irig_out, busy, bit_idx} !== 10'b1110000000) begin
      errors++;
      $display("FAIL first_bit: mark/irig/busy/idx %b want 1110000000", {sym_mark, irig_out, busy, bit_idx});
    end
    capture(3999, -1);
    checks++;
    if ({sy[1], sy[2], sy[3], sy[4], sy[6], sy[7], sy[8], sy[80]} !== {32'd0, 32'd1, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL sec_bits: 1-4 %0d%0d%0d%0d 6-8 %0d%0d%0d b80 %0d want 0110 101 0", sy[1], sy[2], sy[3], sy[4], sy[6], sy[7], sy[8], sy[80]);
    end
    v = 0;
    for (int i = 0; i < 9; i++) if (sy[80+i] == 1) v += 1 << i;
    for (int i = 0; i < 8; i++) if (sy[90+i] == 1) v += 1 << (9 + i);
    checks++;
    if (v != 45296) begin
      errors++;
      $display("FAIL sbs_decode: got %0d want 45296", v);
    end
    for (int b = 0; b < 100; b++) begin
      checks++;
      if (sy[b] != exp_code(b, TA) || bi[b] != b) begin
        errors++;
        $display("FAIL frame_a bit %0d: sym %0d idx %0d want sym %0d idx %0d", b, sy[b], bi[b], exp_code(b, TA), b);
      end
    end
    checks++;
    if (rs_cnt != 0 || extra != 0) begin
      errors++;
      $display("FAIL frame_a_strobes: resync %0d extra %0d want 0 0", rs_cnt, extra);
    end
  endtask
  task automatic test_pulse_width;
    int w;
    for (int b = 0; b < 100; b++) begin
      w = sy[b] == 2 ? 32 : sy[b] == 1 ? 20 : 8;
      checks++;
      if (hi[b] != w) begin
        errors++;
        $display("FAIL width bit %0d: high %0d want %0d", b, hi[b], w);
      end
    end
  endtask
  task automatic test_back_to_back;
    checks++;
    if ({sym_mark, resync, busy, irig_out, bit_idx} !== 11'b10110000000) begin
      errors++;
      $display("FAIL chain_start: mark/resync/busy/irig/idx %b want 10110000000", {sym_mark, resync, busy, irig_out, bit_idx});
    end
    capture(-1, -1);
    for (int b = 0; b < 100; b++) begin
      checks++;
      if (sy[b] != exp_code(b, TB) || hi[b] != (sy[b] == 2 ? 32 : sy[b] == 1 ? 20 : 8)) begin
        errors++;
        $display("FAIL frame_b bit %0d: sym %0d high %0d want sym %0d", b, sy[b], hi[b], exp_code(b, TB));
      end
    end
    checks++;
    if ({busy, irig_out, sym_mark, sym_d0, sym_d1} !== 5'b0 || rs_cnt != 0) begin
      errors++;
      $display("FAIL frame_b_end: busy/irig/strobes %b resync %0d want 0", {busy, irig_out, sym_mark, sym_d0, sym_d1}, rs_cnt);
    end
  endtask
  task automatic test_early_pps;
    set_time(TA);
    start_pps;
    repeat (37 * 40 + 5) tick;
    set_time(TC);
    start_pps;
    checks++;
    if ({resync, sym_mark, irig_out, bit_idx} !== 10'b1110000000) begin
      errors++;
      $display("FAIL early_restart: resync/mark/irig/idx %b want 1110000000", {resync, sym_mark, irig_out, bit_idx});
    end
    capture(-1, -1);
    checks++;
    if (rs_cnt != 1 || hi[0] != 32) begin
      errors++;
      $display("FAIL early_pulse: resync count %0d high %0d want 1 32", rs_cnt, hi[0]);
    end
    for (int b = 0; b < 100; b++) begin
      checks++;
      if (sy[b] != exp_code(b, TC)) begin
        errors++;
        $display("FAIL frame_c bit %0d: sym %0d want %0d", b, sy[b], exp_code(b, TC));
      end
    end
  endtask
  task automatic test_reset_mid;
    int act;
    set_time(TA);
    start_pps;
    repeat (50 * 40 + 3) tick;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({irig_out, sym_d0, sym_d1, sym_mark, busy, resync, bit_idx} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid: got %b want 0", {irig_out, sym_d0, sym_d1, sym_mark, busy, resync, bit_idx});
    end
    tick;
    tick;
    rst_n = 1'b1;
    act = 0;
    repeat (200) begin
      tick;
      if (irig_out | sym_d0 | sym_d1 | sym_mark | busy) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL reset_no_resume: %0d active cycles want 0", act);
    end
    start_pps;
    checks++;
    if ({sym_mark, busy} !== 2'b11) begin
      errors++;
      $display("FAIL reset_new_pps: mark/busy %b want 11", {sym_mark, busy});
    end
    capture(-1, -1);
  endtask
  task automatic test_enable;
    int act;
    set_time(TA);
    start_pps;
    capture(2000, 800);
    for (int b = 0; b < 100; b++) begin
      checks++;
      if (sy[b] != exp_code(b, TA)) begin
        errors++;
        $display("FAIL frame_dis bit %0d: sym %0d want %0d", b, sy[b], exp_code(b, TA));
      end
    end
    checks++;
    if (rs_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dis_end: resync %0d busy %b want 0 0", rs_cnt, busy);
    end
    start_pps;
    act = 0;
    repeat (200) begin
      if (irig_out | sym_d0 | sym_d1 | sym_mark | busy | resync) act++;
      tick;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL dis_pps_ignored: %0d active cycles want 0", act);
    end
    enable = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    pps = 1'b0;
    set_time('0);
    repeat (3) tick;
    test_reset;
    test_frame;
    test_pulse_width;
    test_back_to_back;
    test_early_pps;
    test_reset_mid;
    test_enable;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
